// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file geometry shared by the register file
// and its write arbiter.
package regfile_pkg;

    localparam int NUM_REGS   = 4;
    localparam int REG_ADDR_W = 2;
    localparam int REG_DATA_W = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick. Rotates the eligible
// vector to start at ptr, takes the lowest set bit, rotates back.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] win_idx,
    output logic          valid
);

    logic [N-1:0]  rot;
    logic [PW-1:0] pos;
    logic [PW:0]   sum;

    always_comb begin
        rot = N'({eligible, eligible} >> ptr);
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = PW'(i);
            end
        end
        // Map the rotated position back to a requester index, mod N.
        sum = {1'b0, pos} + {1'b0, ptr};
        if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
        end
        win_idx = sum[PW-1:0];
        valid   = |rot;
        winner  = '0;
        winner[win_idx] = valid;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin owner of the register-file write
// port. Optional grant locking is enabled with REGARB_LOCK_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
`ifdef REGARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      write_enable,
    output logic [ADDR_W-1:0]         write_addr_d,
    output logic [DATA_W-1:0]         write_data,
    output logic                      busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_oh;
    logic [PW-1:0]      pick_idx;
    logic               pick_valid;
    logic               lock_hold;
    logic [NUM_REQ-1:0] next_gnt;
    logic [PW-1:0]      next_idx;
    logic [PW-1:0]      next_ptr;
    logic               next_we;

`ifdef REGARB_LOCK_EN
    assign lock_hold = |(gnt & lock & req);
`else
    assign lock_hold = 1'b0;
`endif

    // The current grantee is masked so it yields for a cycle,
    // unless it holds a lock.
    assign eligible = lock_hold ? req : (req & ~gnt);

    rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .winner   (pick_oh),
        .win_idx  (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        next_gnt = pick_oh;
        next_idx = pick_idx;
        next_we  = pick_valid;
        next_ptr = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
        if (lock_hold) begin
            next_gnt = gnt;
            next_idx = gnt_idx;
            next_we  = 1'b1;
            next_ptr = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt          <= '0;
            write_enable <= 1'b0;
            write_addr_d <= '0;
            write_data   <= '0;
            rr_ptr       <= '0;
            gnt_idx      <= '0;
        end else begin
            gnt          <= next_gnt;
            write_enable <= next_we;
            if (next_we) begin
                write_addr_d <= req_addr[next_idx*ADDR_W +: ADDR_W];
                write_data   <= req_data[next_idx*DATA_W +: DATA_W];
                rr_ptr       <= next_ptr;
                gnt_idx      <= next_idx;
            end
        end
    end

    assign busy = (|eligible) | write_enable;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench; expected writes are queued
// as stimulus is driven and checked when write_enable appears.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] gnt;
        reg_addr_t    addr;
        reg_data_t    data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [N-1:0]              req = '0;
`ifdef REGARB_LOCK_EN
    logic [N-1:0]              lock = '0;
`endif
    logic [N*REG_ADDR_W-1:0]   req_addr = '0;
    logic [N*REG_DATA_W-1:0]   req_data = '0;
    logic [N-1:0]              gnt;
    logic                      write_enable;
    reg_addr_t                 write_addr_d;
    reg_data_t                 write_data;
    logic                      busy;

    exp_t      exp_q[$];
    exp_t      e;
    reg_data_t mem [NUM_REGS] = '{default: '0};
    reg_data_t saved;
    int        n_tests = 0;
    int        n_fail  = 0;

    regfile_write_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
`ifdef REGARB_LOCK_EN
        .lock         (lock),
`endif
        .req_addr     (req_addr),
        .req_data     (req_data),
        .gnt          (gnt),
        .write_enable (write_enable),
        .write_addr_d (write_addr_d),
        .write_data   (write_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Register file model: commits at the end of the grant cycle.
    always @(posedge clk) begin
        if (write_enable) mem[write_addr_d] <= write_data;
    end

    always @(negedge clk) begin
        if (!rst && write_enable) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected gnt=%b addr=%0d data=%h, required no write",
                         gnt, write_addr_d, write_data);
            end else begin
                e = exp_q.pop_front();
                if (gnt !== e.gnt || write_addr_d !== e.addr || write_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_write gnt=%b addr=%0d data=%h, required gnt=%b addr=%0d data=%h",
                             gnt, write_addr_d, write_data, e.gnt, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input reg_addr_t a, input reg_data_t d);
        req_addr[i*REG_ADDR_W +: REG_ADDR_W] = a;
        req_data[i*REG_DATA_W +: REG_DATA_W] = d;
    endtask

    task automatic expect_write(input int i, input reg_addr_t a, input reg_data_t d);
        exp_t x;
        x.gnt  = N'(1) << i;
        x.addr = a;
        x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain pending=%0d, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        n_tests++;
        if (gnt !== '0 || write_enable !== 1'b0 || write_addr_d !== '0 ||
            write_data !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state gnt=%b we=%b addr=%0d data=%h busy=%b, required all 0",
                     gnt, write_enable, write_addr_d, write_data, busy);
        end
        rst = 1'b0;
        set_req(0, 2'd3, 8'h77);
        req = 4'b0001;
        tick();
        n_tests++;
        if (write_enable !== 1'b1 || gnt !== 4'b0001 || write_addr_d !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_prewrite we=%b gnt=%b addr=%0d, required 1 0001 3",
                     write_enable, gnt, write_addr_d);
        end
        #2;
        rst = 1'b1;
        req = '0;
        #1;
        n_tests++;
        if (write_enable !== 1'b0 || gnt !== '0 || write_addr_d !== '0) begin
            n_fail++;
            $display("FAIL reset_async we=%b gnt=%b addr=%0d, required 0 0000 0",
                     write_enable, gnt, write_addr_d);
        end
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (mem[3] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_lost_write R3=%h, required 00", mem[3]);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < N; i++) set_req(i, reg_addr_t'(i), reg_data_t'(8'hC0 + i));
        for (int i = 0; i < N; i++) expect_write(i, reg_addr_t'(i), reg_data_t'(8'hC0 + i));
        expect_write(0, 2'd0, 8'hC0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (write_enable !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL contention_idle cycle=%0d we=%b busy=%b, required 1 1",
                         k, write_enable, busy);
            end
        end
        req = '0;
        tick();
        tick();
        check_drained("contention");
        n_tests++;
        if (mem[2] !== 8'hC2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_end R2=%h busy=%b, required C2 0", mem[2], busy);
        end
    endtask

    task automatic test_single();
        set_req(0, 2'd2, 8'hA5);
        expect_write(0, 2'd2, 8'hA5);
        expect_write(0, 2'd2, 8'hA5);
        req = 4'b0001;
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || write_addr_d !== 2'd2 || write_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_first gnt=%b addr=%0d data=%h, required 0001 2 a5",
                     gnt, write_addr_d, write_data);
        end
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || write_enable !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gap gnt=%b we=%b busy=%b, required 0000 0 1",
                     gnt, write_enable, busy);
        end
        tick();
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_second gnt=%b, required 0001", gnt);
        end
        req = '0;
        tick();
        tick();
        check_drained("single");
        n_tests++;
        if (mem[2] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_regfile R2=%h, required a5", mem[2]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(2, 2'd1, 8'h99);
        expect_write(2, 2'd1, 8'h99);
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        set_req(0, 2'd0, 8'h11);
        set_req(2, 2'd2, 8'h22);
        expect_write(0, 2'd0, 8'h11);
        expect_write(2, 2'd2, 8'h22);
        req = 4'b0101;
        tick();
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_first gnt=%b, required 0001", gnt);
        end
        req = 4'b0100;
        tick();
        n_tests++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_second gnt=%b, required 0100", gnt);
        end
        req = '0;
        tick();
        tick();
        check_drained("wrap");
        n_tests++;
        if (mem[0] !== 8'h11 || mem[2] !== 8'h22 || mem[1] !== 8'h99) begin
            n_fail++;
            $display("FAIL wrap_regfile R0=%h R1=%h R2=%h, required 11 99 22",
                     mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_withdraw();
        saved = mem[3];
        set_req(0, 2'd1, 8'h5A);
        set_req(1, 2'd3, 8'hEE);
        expect_write(0, 2'd1, 8'h5A);
        req = 4'b0011;
        tick();
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL withdraw_gnt gnt=%b, required 0001", gnt);
        end
        req = '0;
        for (int k = 0; k < 3; k++) tick();
        check_drained("withdraw");
        n_tests++;
        if (mem[3] !== saved || mem[1] !== 8'h5A) begin
            n_fail++;
            $display("FAIL withdraw_regfile R3=%h R1=%h, required %h 5a",
                     mem[3], mem[1], saved);
        end
    endtask

`ifdef REGARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        set_req(0, 2'd1, 8'hD0);
        set_req(1, 2'd0, 8'hE1);
        expect_write(0, 2'd1, 8'hD0);
        lock = 4'b0001;
        req  = 4'b0011;
        tick();
        for (int k = 1; k < 3; k++) begin
            set_req(0, reg_addr_t'(k + 1), reg_data_t'(8'hD0 + k));
            expect_write(0, reg_addr_t'(k + 1), reg_data_t'(8'hD0 + k));
            tick();
            n_tests++;
            if (gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL lock_hold k=%0d gnt=%b, required 0001", k, gnt);
            end
        end
        lock = '0;
        req  = 4'b0010;
        expect_write(1, 2'd0, 8'hE1);
        tick();
        n_tests++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL lock_release gnt=%b, required 0010", gnt);
        end
        req = '0;
        tick();
        tick();
        check_drained("lock");
        n_tests++;
        if (mem[3] !== 8'hD2 || mem[0] !== 8'hE1) begin
            n_fail++;
            $display("FAIL lock_regfile R3=%h R0=%h, required d2 e1", mem[3], mem[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_wrap();
        test_withdraw();
`ifdef REGARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
